serial_load_ctrl: RTL

Serial-to-parallel load controller. It sequences a WIDTH-bit register built from D flip-flops: on `start` it shifts in WIDTH serial bits, one per clock, then presents the word with `valid` and holds it until `ack`. It sits between a single-bit serial source and any parallel consumer. It replaces hand-sequenced register loading in the flip-flop lab designs.

---
 rtl/seq_ctrl_pkg.sv | 26 ++
 rtl/dff_en.sv | 37 +++
 rtl/serial_load_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seq_ctrl_pkg
//
// Shared definitions for the sequencing controllers built from the
// flip-flop lab primitives.
//
// Contents:
//   STATE_W             width of the controller state register
//   IDLE / SHIFT / HOLD state codes (2'b11 is unused and illegal)
//   state_is_legal()    helper for decoding the unused code
// ---------------------------------------------------------------------------
package seq_ctrl_pkg;

    localparam int STATE_W = 2;

    // Fixed encodings: other blocks and lab material depend on these values.
    localparam logic [STATE_W-1:0] IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] SHIFT = 2'b01;
    localparam logic [STATE_W-1:0] HOLD  = 2'b10;

    // True for any of the three defined state codes.
    function automatic logic state_is_legal(input logic [STATE_W-1:0] s);
        return (s == IDLE) || (s == SHIFT) || (s == HOLD);
    endfunction

endpackage : seq_ctrl_pkg

// File: rtl/dff_en.sv
// ---------------------------------------------------------------------------
// dff_en
//
// Single D flip-flop with load enable, synchronous clear and asynchronous
// active-low reset. Clear takes priority over enable.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous reset, active low (q -> 0)
//   clr  in   synchronous clear (q -> 0 on the next edge)
//   en   in   load enable (q -> d on the next edge)
//   d    in   data input
//   q    out  registered output
// ---------------------------------------------------------------------------
module dff_en (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours; this is what makes a
    // chain of these cells behave as a shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : dff_en

// File: rtl/serial_load_ctrl.sv
// ---------------------------------------------------------------------------
// serial_load_ctrl
//
// Serial-to-parallel load controller. A start request opens a load; WIDTH
// serial bits are then captured one per clock into a register built from
// dff_en cells. The completed word is presented with valid and held until
// the consumer acknowledges it. A start together with ack re-enters SHIFT
// directly, giving one word every WIDTH+1 cycles.
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: first received bit lands in data_out[WIDTH-1]
//              0: first received bit lands in data_out[0]
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low
//   start     in   request a load (IDLE, or HOLD together with ack)
//   ser_in    in   serial data, captured on every edge in SHIFT
//   abort     in   cancel the load in progress (SHIFT only)
//   ack       in   consumer accepts the word (HOLD only)
//   busy      out  high in SHIFT
//   valid     out  high in HOLD
//   data_out  out  shift register contents (meaningful while valid)
//   bit_cnt   out  bits captured so far in the current load
//
// busy and valid are decoded from the state register only, so no input
// reaches an output without passing through a flop.
// ---------------------------------------------------------------------------
module serial_load_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             abort,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] bit_cnt
);

    // Count value present while the final bit of a word is being captured.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               shift_en;
    logic               shift_clr;
    logic [WIDTH-1:0]   shift_d;

    // -----------------------------------------------------------------------
    // Next-state, counter and shift-register control
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shift_en  = 1'b0;
        shift_clr = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    shift_clr = 1'b1;
                    cnt_nxt   = '0;
                end
            end

            SHIFT: begin
                // abort wins over capturing a bit, including the last one.
                if (abort) begin
                    state_nxt = IDLE;
                    shift_clr = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    shift_en = 1'b1;
                    cnt_nxt  = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_CNT) begin
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                // start is only honoured together with ack here.
                if (ack) begin
                    cnt_nxt = '0;
                    if (start) begin
                        state_nxt = SHIFT;
                        shift_clr = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                // Unused code: fall back to a clean IDLE on the next edge.
                state_nxt = IDLE;
                shift_clr = 1'b1;
                cnt_nxt   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and bit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    assign busy  = (state == SHIFT);
    assign valid = (state == HOLD);

    // -----------------------------------------------------------------------
    // Shift register: WIDTH dff_en cells with direction-dependent wiring.
    // The register cells are reset as well, because data_out must read 0
    // immediately after reset.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (MSB_FIRST) begin : g_msb
            // Data moves toward the MSB; new bits enter at bit 0.
            if (i == 0) begin : g_in
                assign shift_d[i] = ser_in;
            end else begin : g_link
                assign shift_d[i] = data_out[i-1];
            end
        end else begin : g_lsb
            // Data moves toward the LSB; new bits enter at the top bit.
            if (i == WIDTH - 1) begin : g_in
                assign shift_d[i] = ser_in;
            end else begin : g_link
                assign shift_d[i] = data_out[i+1];
            end
        end

        dff_en u_dff (
            .clk (clk),
            .rst (rst),
            .clr (shift_clr),
            .en  (shift_en),
            .d   (shift_d[i]),
            .q   (data_out[i])
        );
    end

endmodule : serial_load_ctrl
